sseg_scan_driver: RTL and testbench

- Parametrised N-digit 7-segment scan driver, successor to the fixed 4-digit display path behind the ALU register activity.
- Accepts a binary value with a load strobe and shows it in hex or decimal.
- Decimal mode uses a sequential double-dabble conversion; digits are time-multiplexed with a programmable refresh prescaler.
- Sits between datapath result registers and board pins (active-low anodes and segments).

---
 rtl/sseg_pkg.sv | 66 ++++++
 rtl/sseg_scan_driver_bin2bcd_seq.sv | 100 ++++++++++
 rtl/sseg_scan_driver.sv | 119 +++++++++++
 tb/tb_sseg_scan_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types and constants for the 7-segment scan driver.
//   seg_t        - active-low segment vector, order {g,f,e,d,c,b,a}
//   SEG_OFF      - all segments dark (blank digit)
//   SEG_DASH     - middle bar only, shown on every digit when the value
//                  does not fit the display
//   SEG_0..SEG_F - hex glyphs
//   b2b_state_t  - state of the sequential binary-to-BCD engine
//   hex_to_seg   - nibble to glyph lookup
//   bcd_regw     - width of the BCD register for a given digit count
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF  = 7'b1111111;
  localparam seg_t SEG_DASH = 7'b0111111;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  typedef enum logic {
    B2B_IDLE  = 1'b0,
    B2B_SHIFT = 1'b1
  } b2b_state_t;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

  function automatic int bcd_regw(input int n_digits);
    return 4 * n_digits;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one input bit per cycle.
//   clk, reset : clock, synchronous active-high reset (aborts a conversion)
//   start      : begin converting bin; ignored while busy
//   bin        : binary input, sampled on the start edge
//   busy       : high for exactly WIDTH cycles after the start edge; this is
//                the engine state (B2B_SHIFT) made visible
//   done       : high during the last busy cycle; bcd/ovf carry the final
//                result in that cycle, so a consumer registering them on
//                this edge updates on the same edge busy falls
//   bcd        : converted result, valid while done
//   ovf        : a 1 was shifted out of the top BCD bit (value too large)
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int N_DIGITS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [bcd_regw(N_DIGITS)-1:0] bcd,
  output logic                          ovf
);

  localparam int BW = bcd_regw(N_DIGITS);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  b2b_state_t     state_q, state_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic [BW-1:0]    bcd_q, bcd_n;
  logic             ovf_q, ovf_n;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;
  logic             carry_out;
  logic             last;

  // Add-3 to every digit >= 5, then shift the next input bit in at the LSB.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    shifted   = {adj[BW-2:0], sh_q[WIDTH-1]};
    carry_out = adj[BW-1];
  end

  assign last = (state_q == B2B_SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign busy = (state_q == B2B_SHIFT);
  assign done = last;
  assign bcd  = shifted;
  assign ovf  = ovf_q | carry_out;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sh_n    = sh_q;
    bcd_n   = bcd_q;
    ovf_n   = ovf_q;
    case (state_q)
      B2B_IDLE: begin
        if (start) begin
          state_n = B2B_SHIFT;
          cnt_n   = '0;
          sh_n    = bin;
          bcd_n   = '0;
          ovf_n   = 1'b0;
        end
      end
      default: begin
        sh_n  = sh_q << 1;
        bcd_n = shifted;
        ovf_n = ovf_q | carry_out;
        cnt_n = cnt_q + CW'(1);
        if (last) state_n = B2B_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= B2B_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sh_q    <= sh_n;
      bcd_q   <= bcd_n;
      ovf_q   <= ovf_n;
    end
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: N-digit multiplexed 7-segment driver, hex or decimal.
//   clk, reset : clock, synchronous active-high reset
//   value      : binary value to display
//   load       : capture value and dec_mode (ignored while busy)
//   dec_mode   : 0 = show hex nibbles, 1 = convert to decimal first
//   busy       : decimal conversion in progress
//   overflow   : displayed value does not fit; all digits show a dash
//   anodes     : active-low one-hot digit enable, anodes[0] = least significant
//   segments   : active-low {g,f,e,d,c,b,a}
// Each digit stays enabled for REFRESH_CYCLES clocks. anodes/segments are
// registered, so they trail a change of digit index or display by one cycle.
// Build option SSEG_LEADING_ZERO_BLANK_EN: digits above the most significant
// non-zero digit are blanked (digit 0 never is; no effect while overflow).
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int N_DIGITS       = 8,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    value,
  input  logic                load,
  input  logic                dec_mode,
  output logic                busy,
  output logic                overflow,
  output logic [N_DIGITS-1:0] anodes,
  output logic [6:0]          segments
);

  localparam int BW = bcd_regw(N_DIGITS);
  localparam int PW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int EW = WIDTH + BW;

  logic [BW-1:0]       disp_q;
  logic                ovf_q;
  logic [PW-1:0]       presc_q;
  logic [IW-1:0]       idx_q;
  logic [N_DIGITS-1:0] anodes_q;
  seg_t                seg_q;

  logic                conv_start;
  logic                conv_done;
  logic                conv_ovf;
  logic [BW-1:0]       conv_bcd;

  // Zero-extended copy: nibbles above WIDTH read 0, bits above the display
  // width flag a hex overflow.
  logic [EW-1:0]       val_ext;
  logic                hex_ovf;
  logic                hex_load;
  seg_t                glyph_n;
  logic [3:0]          cur_nib;

  assign val_ext    = EW'(value);
  assign hex_ovf    = |(val_ext >> BW);
  assign conv_start = load && !busy && dec_mode;
  assign hex_load   = load && !busy && !dec_mode;

  bin2bcd_seq #(
    .WIDTH   (WIDTH),
    .N_DIGITS(N_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .reset(reset),
    .start(conv_start),
    .bin  (value),
    .busy (busy),
    .done (conv_done),
    .bcd  (conv_bcd),
    .ovf  (conv_ovf)
  );

  always_comb begin
    cur_nib = disp_q[{idx_q, 2'b00} +: 4];
    glyph_n = hex_to_seg(cur_nib);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    if ((idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0)) glyph_n = SEG_OFF;
`endif
    if (ovf_q) glyph_n = SEG_DASH;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      presc_q  <= '0;
      idx_q    <= '0;
      anodes_q <= ~N_DIGITS'(1);
      seg_q    <= SEG_0;
    end else begin
      if (conv_done) begin
        disp_q <= conv_bcd;
        ovf_q  <= conv_ovf;
      end else if (hex_load) begin
        disp_q <= val_ext[BW-1:0];
        ovf_q  <= hex_ovf;
      end

      if (presc_q == PW'(REFRESH_CYCLES - 1)) begin
        presc_q <= '0;
        if (idx_q == IW'(N_DIGITS - 1)) idx_q <= '0;
        else                            idx_q <= idx_q + IW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end

      anodes_q <= ~(N_DIGITS'(1) << idx_q);
      seg_q    <= glyph_n;
    end
  end

  assign overflow = ovf_q;
  assign anodes   = anodes_q;
  assign segments = seg_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver (WIDTH=16, N_DIGITS=4, REFRESH_CYCLES=2).
// Expected digit glyphs come from an independent model of the value and are
// queued in exp_q; each entry is popped when its anode is next scanned.
module tb_sseg_scan_driver;

  localparam int WIDTH = 16;
  localparam int ND    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] value;
  logic             load;
  logic             dec_mode;
  logic             busy;
  logic             overflow;
  logic [ND-1:0]    anodes;
  logic [6:0]       segments;

  int total;
  int bad;
  bit mon_en;
  logic [8:0] exp_q[$];   // {digit index[1:0], glyph[6:0]}

  sseg_scan_driver #(
    .WIDTH         (WIDTH),
    .N_DIGITS      (ND),
    .REFRESH_CYCLES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .load    (load),
    .dec_mode(dec_mode),
    .busy    (busy),
    .overflow(overflow),
    .anodes  (anodes),
    .segments(segments)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exactly one anode low every cycle from the first reset edge on.
  always @(negedge clk) begin
    if (mon_en) chk("anode_onehot", 32'($countones(~anodes)), 32'd1);
  end

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001;
      14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  // driver tasks
  task automatic do_load(input logic [WIDTH-1:0] v, input logic dec);
    @(negedge clk);
    value    = v;
    dec_mode = dec;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // Count negedges with busy high; ends at the negedge after busy falls.
  task automatic wait_busy_fall(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  // scoreboard: push expected glyphs for value, then pop against the scan
  task automatic check_display(input int v, input bit dec);
    int  div;
    int  nib;
    int  higher;
    bit  ovf;
    bit  blank;
    logic [6:0] g;
    logic [8:0] e;
    int  d;
    int  waited;
    ovf = dec && (v > 9999);
    div = 1;
    for (int i = 0; i < ND; i++) begin
      nib    = dec ? (v / div) % 10 : (v >> (4 * i)) & 15;
      higher = dec ? v / div : v >> (4 * i);
      blank  = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      blank  = (higher == 0) && (i != 0);
`endif
      g = ovf ? 7'b0111111 : (blank ? 7'b1111111 : glyph(nib));
      exp_q.push_back({2'(i), g});
      div = div * 10;
    end
    chk("overflow", 32'(overflow), 32'(ovf));
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      d = int'(e[8:7]);
      waited = 0;
      while (anodes !== ~(4'b0001 << d) && waited < 20) begin
        waited++;
        @(negedge clk);
      end
      if (waited >= 20) chk($sformatf("scan_timeout_d%0d", d), 32'(anodes), 32'(~(4'b0001 << d)));
      else              chk($sformatf("seg_d%0d", d), 32'(segments), 32'(e[6:0]));
    end
  endtask

  initial begin
    int n;
    bit saw_busy;
    total = 0; bad = 0; mon_en = 1'b0;
    reset = 1'b1; value = '0; load = 1'b0; dec_mode = 1'b0;

    // reset held 3 cycles
    repeat (3) begin
      @(negedge clk);
      mon_en = 1'b1;
    end
    chk("rst_anodes", 32'(anodes), 32'(4'b1110));
    chk("rst_segments", 32'(segments), 32'(7'b1000000));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    check_display(0, 1'b0);

    // hex load, busy must stay low
    do_load(16'hA3F0, 1'b0);
    saw_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b0) saw_busy = 1'b1;
      @(negedge clk);
    end
    chk("hex_busy", 32'(saw_busy), 32'd0);
    check_display(16'hA3F0, 1'b0);

    // decimal 1234: busy exactly 16 cycles
    do_load(16'd1234, 1'b1);
    wait_busy_fall(n);
    chk("dec1234_busy_cycles", 32'(n), 32'd16);
    check_display(1234, 1'b1);

    // decimal 65535 overflows, hex 0x0042 clears it
    do_load(16'hFFFF, 1'b1);
    wait_busy_fall(n);
    chk("dec65535_busy_cycles", 32'(n), 32'd16);
    check_display(65535, 1'b1);
    do_load(16'h0042, 1'b0);
    check_display(16'h0042, 1'b0);

    // second load mid-conversion is ignored
    do_load(16'd7, 1'b1);
    repeat (2) @(negedge clk);
    value = 16'd9999; dec_mode = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_busy_fall(n);
    chk("ignored_busy_fall", 32'(busy), 32'd0);
    check_display(7, 1'b1);

    // reset at busy cycle 8 aborts the conversion
    do_load(16'd1234, 1'b1);
    repeat (7) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    check_display(0, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
